if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Fetch-to-decode pipeline buffer sitting directly downstream of the instruction memory fetch stage.
- Captures the fetched instruction word, its PC, and PC+4 into a small in-order queue.
- Presents the queue head to decode with a valid/ready handshake.
- Generates the stall_flag back to fetch and drops wrong-path instructions on a branch flush.

Parameters:
- DATA_W, 32, width of instruction, PC and next-PC fields.
- DEPTH, 2, queue entries; power of two, legal range 2..8.
- NOP_INSTN, 32'h0000_0000, instruction word driven when the queue is empty or after a flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- inp_instn  input  DATA_W  fetched instruction word.
- pc_to_branch  input  DATA_W  PC of the fetched instruction.
- nextpc  input  DATA_W  PC+4 of the fetched instruction.
- stall_flag  output  1  high when the queue is full; fetch holds its PC.
- flush  input  1  branch taken or redirect from a later stage; discard all held entries.
- out_valid  output  1  the head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_instn  output  DATA_W  head instruction word.
- out_pc  output  DATA_W  head PC.
- out_nextpc  output  DATA_W  head PC+4.
- perf_stall_cycles  output  32  stall counter (see Optional Feature).
- perf_flushes  output  32  flush counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - out_valid = 0; out_instn = NOP_INSTN; out_pc = 0; out_nextpc = 0.
  - stall_flag = 0.
  - Perf counters = 0.
- Occupancy states are derived from count (width clog2(DEPTH)+1):
  - EMPTY (count=0).
  - PARTIAL (0<count<DEPTH).
  - FULL (count=DEPTH).
- stall_flag = (count==DEPTH). It is driven from registered state only; there is no combinational path from in_valid or out_ready.
- Push: when in_valid && !stall_flag && !flush at a rising edge:
  - Write {inp_instn, pc_to_branch, nextpc} to entry[wr_ptr].
  - wr_ptr increments modulo DEPTH.
- Pop: when out_valid && out_ready && !flush at a rising edge, rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: count is unchanged. This is legal in PARTIAL. In FULL the push is refused because stall_flag=1, even if a pop occurs in the same cycle.
- Push while EMPTY: the output is visible on out_* in the cycle after the edge (1-cycle latency). There is no same-cycle bypass.
- Output mux: out_valid = (count!=0). out_* is driven from entry[rd_ptr] when valid; otherwise out_instn = NOP_INSTN and out_pc/out_nextpc = 0.
- Pointer wrap-around: pointers wrap from DEPTH-1 to 0. The fill sequence A,B, pop A, push C must yield out order A,B,C.
- Flush (synchronous, highest priority):
  - At the edge: count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop presented in the same cycle is discarded.
  - The next cycle shows out_valid=0 and stall_flag=0.
- in_valid while FULL: the fetch side holds its inputs. The buffer neither samples nor overwrites any entry.
- Reset asserted mid-operation: all state clears immediately. Entry storage contents are don't-care.
- X-safety: out_instn must never expose uninitialised storage; the empty case always drives NOP_INSTN.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- With the macro defined:
  - perf_stall_cycles increments on every cycle with in_valid && stall_flag.
  - perf_flushes increments on every cycle with flush=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Without the macro:
  - Both ports remain present and are tied to 32'd0.
  - No counter flops are synthesised.

Decomposition:
- Shared package if_pkg holds:
  - DATA_W default.
  - NOP_INSTN constant.
  - The if_entry_t typedef {instn, pc, nextpc}, each DATA_W.
- Sub-module if_id_entry_ram: DEPTH x if_entry_t register file.
  - Synchronous write port, combinational read port.
  - No reset on the storage.
- The top level owns the pointers, count, flush, handshake and perf logic.

Test Plan:
- Reset then idle: out_valid=0, out_instn=32'h0, stall_flag=0, and counters=0 for 10 cycles.
- Single push of inp_instn=32'h2002_0005, pc=0, nextpc=4, with out_ready=1: one cycle later out_valid=1, out_instn=32'h2002_0005, out_pc=0, out_nextpc=4; the following cycle out_valid=0.
- Back-pressure: out_ready=0 and push pc=0,4,8 on consecutive cycles: stall_flag=1 after the second push, the pc=8 push is refused and held, and after out_ready=1 the output order is 0,4,8.
- Wrap-around with DEPTH=2: push/pop interleaved for 6 instructions (pc 0..20) gives in-order delivery with no loss or duplication.
- Flush while FULL, with a simultaneous push of pc=12: the next cycle shows out_valid=0 and stall_flag=0, and pc=12 never appears; a subsequent push of pc=40 is the first entry out.
- With IFID_PERF_CNT_EN: 3 stalled cycles and 1 flush give perf_stall_cycles=3 and perf_flushes=1. Without the macro, both counters read 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the fetch-to-decode buffer: default field width,
// the bubble instruction word and the queue entry layout.
package if_pkg;

    localparam int unsigned DATA_W = 32;

    // Instruction word driven whenever decode sees no valid entry
    localparam logic [DATA_W-1:0] NOP_INSTN = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] instn;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] nextpc;
    } if_entry_t;

endpackage

// File: rtl/if_id_entry_ram.sv
// DEPTH x if_entry_t register file for the fetch-to-decode queue.
// Synchronous write, combinational read. The storage has no reset; the top
// level never exposes an entry that has not been written.
module if_id_entry_ram
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  if_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output if_entry_t        rd_data
);

    if_entry_t mem [DEPTH];

    // Write the addressed entry on the rising edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline buffer: a small in-order queue of
// {instn, pc, nextpc} with a valid/ready output, a full-driven stall back to
// fetch and a synchronous flush that discards wrong-path entries.
// Optional feature macro: IFID_PERF_CNT_EN (stall-cycle and flush counters).
module if_id_buffer
    import if_pkg::*;
#(
    parameter int unsigned DATA_W    = if_pkg::DATA_W,
    parameter int unsigned DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_INSTN = if_pkg::NOP_INSTN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] inp_instn,
    input  logic [DATA_W-1:0] pc_to_branch,
    input  logic [DATA_W-1:0] nextpc,
    output logic              stall_flag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instn,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_nextpc,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushes
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic      push;
    logic      pop;
    if_entry_t wr_data;
    if_entry_t head;

    // Status comes only from registered count, so stall has no path from
    // in_valid or out_ready
    assign stall_flag = (count == CNT_FULL);
    assign out_valid  = (count != '0);

    // Flush overrides both sides of the handshake
    assign push = in_valid && !stall_flag && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_data = '{instn: inp_instn, pc: pc_to_branch, nextpc: nextpc};

    if_id_entry_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointer and occupancy update; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head mux; an empty queue shows a bubble, never unwritten storage
    always_comb begin
        out_instn  = NOP_INSTN;
        out_pc     = '0;
        out_nextpc = '0;
        if (out_valid) begin
            out_instn  = head.instn;
            out_pc     = head.pc;
            out_nextpc = head.nextpc;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Saturating counters of stalled fetch cycles and flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (in_valid && stall_flag && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush && (perf_flushes != 32'hFFFF_FFFF))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flushes      = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (DEPTH=2).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] inp_instn;
    logic [31:0] pc_to_branch;
    logic [31:0] nextpc;
    logic        stall_flag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instn;
    logic [31:0] out_pc;
    logic [31:0] out_nextpc;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;

    int tests_run = 0;
    int tests_failed = 0;

    if_id_buffer #(.DATA_W(32), .DEPTH(2), .NOP_INSTN(32'h0)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .inp_instn         (inp_instn),
        .pc_to_branch      (pc_to_branch),
        .nextpc            (nextpc),
        .stall_flag        (stall_flag),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instn         (out_instn),
        .out_pc            (out_pc),
        .out_nextpc        (out_nextpc),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one fetch beat; instruction word derived from pc
    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid     = v;
        pc_to_branch = pc;
        nextpc       = pc + 32'd4;
        inp_instn    = 32'hA000_0000 | pc;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        inp_instn = '0; pc_to_branch = '0; nextpc = '0;
        #3;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_instn", out_instn, 32'h0);
            if (stall_flag !== 1'b0 || perf_stall_cycles !== 32'd0 || perf_flushes !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_idle: stall %b perf %h/%h expected 0", stall_flag, perf_stall_cycles, perf_flushes);
            end
            tests_run++;
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; inp_instn = 32'h2002_0005; pc_to_branch = 32'd0; nextpc = 32'd4;
        step();
        in_valid = 1'b0;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_instn", out_instn, 32'h2002_0005);
        chk("single_pc", out_pc, 32'd0);
        chk("single_nextpc", out_nextpc, 32'd4);
        step();
        chk("single_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("single_drain_instn", out_instn, 32'h0);
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd0); step();
        chk("bp_stall_after1", {31'd0, stall_flag}, 32'd0);
        drive(1'b1, 32'd4); step();
        chk("bp_stall_after2", {31'd0, stall_flag}, 32'd1);
        chk("bp_head0", out_pc, 32'd0);
        drive(1'b1, 32'd8); step();
        chk("bp_refused_stall", {31'd0, stall_flag}, 32'd1);
        chk("bp_refused_head", out_pc, 32'd0);
        out_ready = 1'b1; step();
        chk("bp_pop_full_stall", {31'd0, stall_flag}, 32'd0);
        chk("bp_order1", out_pc, 32'd4);
        chk("bp_order1_next", out_nextpc, 32'd8);
        step();
        drive(1'b0, 32'd0);
        chk("bp_order2", out_pc, 32'd8);
        chk("bp_order2_instn", out_instn, 32'hA000_0008);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        drive(1'b1, 32'd0); step();
        for (int p = 4; p <= 20; p += 4) begin
            chk("wrap_head", out_pc, 32'(p - 4));
            drive(1'b1, 32'(p)); out_ready = 1'b1; step();
            chk("wrap_nostall", {31'd0, stall_flag}, 32'd0);
        end
        drive(1'b0, 32'd0);
        chk("wrap_last", out_pc, 32'd20);
        chk("wrap_last_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("wrap_empty", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'd0); step();
        drive(1'b1, 32'd4); step();
        chk("flush_full", {31'd0, stall_flag}, 32'd1);
        drive(1'b1, 32'd12); flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0; drive(1'b0, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_stall", {31'd0, stall_flag}, 32'd0);
        chk("flush_instn", out_instn, 32'h0);
        step(); step();
        chk("flush_no12", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 32'd40); out_ready = 1'b0; step();
        drive(1'b0, 32'd0);
        chk("flush_first40", out_pc, 32'd40);
        chk("flush_first40_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1; step();
        chk("flush_drain", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef IFID_PERF_CNT_EN
        exp_stall = 32'd3; exp_flush = 32'd1;
`else
        exp_stall = 32'd0; exp_flush = 32'd0;
`endif
        reset = 1'b0; #2; reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'd0); step();
        drive(1'b1, 32'd4); step();
        for (int i = 0; i < 3; i++) step();
        drive(1'b0, 32'd0); flush = 1'b1; step();
        flush = 1'b0;
        chk("perf_stall_cycles", perf_stall_cycles, exp_stall);
        chk("perf_flushes", perf_flushes, exp_flush);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'd0); step();
        drive(1'b1, 32'd4); step();
        drive(1'b0, 32'd0);
        chk("areset_pre_full", {31'd0, stall_flag}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset_stall", {31'd0, stall_flag}, 32'd0);
        chk("areset_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_perf", perf_stall_cycles | perf_flushes, 32'd0);
        reset = 1'b1;
        step();
        chk("areset_still_empty", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_wrap();
        test_flush();
        test_perf();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
